// File: rtl/opcode_sequencer_pkg.sv
// Shared definitions for the opcode sequencer and anything that talks to it:
// word type, HALT marker and FSM state encoding.
package opcode_sequencer_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t HALT_OPCODE = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_halt(input word_t w);
    return w == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/opcode_sequencer_if.sv
// Program-load / run-control / issue bundle between the sequencer and its host.
interface opcode_sequencer_if #(
  parameter int ADDR_WIDTH = 4
) ();
  import opcode_sequencer_pkg::*;

  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  word_t                 prog_data;
  logic                  start;
  logic                  stall;
  word_t                 opcode;
  logic                  execute;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] pc;

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stall,
    output opcode, execute, busy, done, pc
  );

  modport master (
    output prog_we, prog_addr, prog_data, start, stall,
    input  opcode, execute, busy, done, pc
  );

endinterface

// File: rtl/opcode_sequencer_prog_mem.sv
// Program store: one synchronous write port, one combinational read port.
module prog_mem
  import opcode_sequencer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  word_t                 wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output word_t                 rdata_o
);

  word_t mem_q [DEPTH];

  // NOTE: storage is not reset; program contents survive rst_n and must be loaded before a run.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: loads a small program in IDLE, then streams it out one
// word per non-stalled cycle until HALT or the last entry.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  opcode_sequencer_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  word_t                 opcode_q;
  logic                  execute_q;
  logic                  done_q;

  word_t                 fetch_word;
  logic                  mem_we;

  // Writes are only honoured in IDLE so a running program cannot be altered.
  assign mem_we = bus.prog_we && (state_q == ST_IDLE);

  prog_mem #(
    .DEPTH      (PROG_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (bus.prog_addr),
    .wdata_i (bus.prog_data),
    .raddr_i (pc_q),
    .rdata_o (fetch_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      execute_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      execute_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
          end
        end
        ST_RUN: begin
          // Stall wins over HALT: nothing is evaluated on a stalled cycle.
          if (!bus.stall) begin
            if (is_halt(fetch_word)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              opcode_q  <= fetch_word;
              execute_q <= 1'b1;
              pc_q      <= pc_q + ADDR_WIDTH'(1);
              if (pc_q == LAST_ADDR) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.opcode  = opcode_q;
  assign bus.execute = execute_q;
  assign bus.done    = done_q;
  assign bus.pc      = pc_q;
  assign bus.busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_opcode_sequencer.sv
// Self-checking bench for opcode_sequencer: vector table, directed corner
// sequences and randomized runs against a program-level reference model.
module tb_opcode_sequencer;
  import opcode_sequencer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opcode_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  opcode_sequencer #(
    .PROG_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    word_t         data;
    logic          start;
    logic          stall;
    logic          ex;
    word_t         op;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
  } vec_t;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t last_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic ex, input word_t op,
                            input logic busy, input logic done, input logic [AW-1:0] pc);
    check({tag, ".execute"}, 32'(bus.execute), 32'(ex));
    check({tag, ".opcode"},  32'(bus.opcode),  32'(op));
    check({tag, ".busy"},    32'(bus.busy),    32'(busy));
    check({tag, ".done"},    32'(bus.done),    32'(done));
    check({tag, ".pc"},      32'(bus.pc),      32'(pc));
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input word_t data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  function automatic vec_t v(input logic we, input logic [AW-1:0] a, input word_t d,
                             input logic st, input logic sl, input logic ex, input word_t op,
                             input logic b, input logic dn, input logic [AW-1:0] pc);
    vec_t r;
    r.we = we; r.addr = a; r.data = d; r.start = st; r.stall = sl;
    r.ex = ex; r.op = op; r.busy = b; r.done = dn; r.pc = pc;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t  tbl[$];
    word_t prog [DEPTH];

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    last_op = 16'h0000;

    // Load-and-run, stall, write+start on same cycle with HALT at entry 0.
    //           we  a  data      st sl   ex op        busy done pc
    tbl.push_back(v(1, 0, 16'h1234, 0, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(v(1, 1, 16'h5678, 0, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(v(1, 2, 16'hFFFF, 0, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0,  0, 16'h0000, 1, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  1, 16'h1234, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  1, 16'h5678, 1, 0, 2));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 1, 2));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 0, 2));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0,  0, 16'h5678, 1, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  1, 16'h1234, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 1,  0, 16'h1234, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 1,  0, 16'h1234, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 1,  0, 16'h1234, 1, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  1, 16'h5678, 1, 0, 2));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 1, 2));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 0, 2));
    tbl.push_back(v(1, 0, 16'hFFFF, 1, 0,  0, 16'h5678, 1, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0,  0, 16'h5678, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.prog_we   = tbl[i].we;
      bus.prog_addr = tbl[i].addr;
      bus.prog_data = tbl[i].data;
      bus.start     = tbl[i].start;
      bus.stall     = tbl[i].stall;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].ex, tbl[i].op, tbl[i].busy, tbl[i].done, tbl[i].pc);
    end
    idle_inputs();
    last_op = 16'h5678;

    // Writes during RUN must not reach the program.
    load_word(4'd0, 16'h1111);
    load_word(4'd1, 16'h2222);
    load_word(4'd2, 16'h3333);
    load_word(4'd3, HALT_OPCODE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd1; bus.prog_data = 16'hAAAA;
    tick();
    check_outs("wrun.issue0", 1'b1, 16'h1111, 1'b1, 1'b0, 4'd1);
    tick();
    bus.prog_we = 1'b0;
    check_outs("wrun.issue1", 1'b1, 16'h2222, 1'b1, 1'b0, 4'd2);
    tick();
    check_outs("wrun.issue2", 1'b1, 16'h3333, 1'b1, 1'b0, 4'd3);
    tick();
    check_outs("wrun.halt", 1'b0, 16'h3333, 1'b0, 1'b1, 4'd3);

    // Full depth: no HALT, done coincides with the last issue and pc wraps.
    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), word_t'(i));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check_outs($sformatf("full%0d", i), 1'b1, word_t'(i), (i != DEPTH - 1),
                 (i == DEPTH - 1), AW'((i + 1) % DEPTH));
    end
    tick();
    check_outs("full.after", 1'b0, 16'h000F, 1'b0, 1'b0, 4'd0);
    last_op = 16'h000F;

    // Randomized runs: expected issue stream derived from the program contents
    // and the stall schedule, with stray writes and starts during RUN.
    for (int iter = 0; iter < 25; iter++) begin
      int   n_issue;
      int   idx;
      int   cyc;
      logic ended;
      logic exp_ex;

      n_issue = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        if (i < n_issue)       prog[i] = word_t'($urandom_range(0, 16'hFFFE));
        else if (i == n_issue) prog[i] = HALT_OPCODE;
        else                   prog[i] = word_t'($urandom);
        load_word(AW'(i), prog[i]);
      end
      bus.start = 1'b1;
      tick();
      check_outs($sformatf("rand%0d.start", iter), 1'b0, last_op, 1'b1, 1'b0, 4'd0);

      idx = 0; cyc = 0; ended = 1'b0;
      while (!ended && cyc < 100) begin
        bus.stall     = ($urandom_range(0, 3) == 0);
        bus.start     = 1'($urandom_range(0, 1));
        bus.prog_we   = 1'($urandom_range(0, 1));
        bus.prog_addr = AW'($urandom);
        bus.prog_data = word_t'($urandom);
        exp_ex = 1'b0;
        if (!bus.stall) begin
          if (idx < n_issue) begin
            exp_ex  = 1'b1;
            last_op = prog[idx];
            idx++;
            if (idx == DEPTH) ended = 1'b1;
          end else begin
            ended = 1'b1;
          end
        end
        tick();
        check_outs($sformatf("rand%0d.c%0d", iter, cyc), exp_ex, last_op, !ended, ended,
                   AW'(idx % DEPTH));
        cyc++;
      end
      check($sformatf("rand%0d.ended", iter), 32'(ended), 32'd1);
      idle_inputs();
      tick();
      check_outs($sformatf("rand%0d.idle", iter), 1'b0, last_op, 1'b0, 1'b0, AW'(idx % DEPTH));
    end

    // Reset during the second issue: outputs clear without a clock edge.
    load_word(4'd0, 16'h0A0A);
    load_word(4'd1, 16'h0B0B);
    load_word(4'd2, 16'h0C0C);
    load_word(4'd3, HALT_OPCODE);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_outs("rst.issue1", 1'b1, 16'h0B0B, 1'b1, 1'b0, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst.async", 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs($sformatf("rst.quiet%0d", i), 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_outs("rst.restart", 1'b1, 16'h0A0A, 1'b1, 1'b0, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, number of 16-bit program entries (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, equal to log2(PROG_DEPTH).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; there are no other clocks or resets.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 prog_we  input  1  program write strobe.
REQ-007 prog_addr  input  ADDR_WIDTH  program write address.
REQ-008 prog_data  input  16  program word to write.
REQ-009 start  input  1  run request, one-cycle pulse or level.
REQ-010 stall  input  1  holds issue while high.
REQ-011 opcode  output  16  opcode for the core array.
REQ-012 execute  output  1  one-cycle strobe qualifying opcode.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse when a program ends.
REQ-015 pc  output  ADDR_WIDTH  address of the next word to fetch.

Function
REQ-016 SHALL hold the program in an internal PROG_DEPTH x 16 register array.
REQ-017 SHALL write prog_data into entry prog_addr on the clock edge where prog_we=1, but only in IDLE; writes in RUN are ignored.
REQ-018 SHALL implement a two-state FSM, IDLE and RUN:
- IDLE -> RUN on start=1, with pc cleared to 0.
- start in RUN is ignored.
REQ-019 SHALL issue in RUN on any cycle with stall=0 and mem[pc] != 16'hFFFF:
- register opcode <= mem[pc] and execute <= 1;
- increment pc.
First execute is seen one cycle after the start edge.
REQ-020 SHALL, in RUN with stall=1, drive execute <= 0, hold opcode and pc, and stay in RUN.
REQ-021 SHALL, in RUN with stall=0 and mem[pc] == 16'hFFFF (HALT):
- not issue that word (execute <= 0);
- go to IDLE and pulse done for one cycle;
- leave opcode holding its last issued value.
REQ-022 SHALL treat issuing entry PROG_DEPTH-1 as the end of program:
- it is issued normally;
- on the same edge the block goes to IDLE, pulses done, and pc wraps to 0.
REQ-023 SHALL let stall take priority over HALT detection; HALT is evaluated only on non-stalled cycles.
REQ-024 SHALL give execute exactly a one-cycle width per issued word, with no back-to-back duplicates of one pc.
REQ-025 SHALL register all outputs except busy, which decodes state == RUN.
REQ-026 SHALL, on a prog_we and start on the same IDLE cycle, perform the write first, so the new word is visible to the run.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously set:
- state=IDLE, pc=0, opcode=16'h0000;
- execute=0, done=0, busy=0.
REQ-028 SHALL leave program array contents unaffected by reset; they are undefined after power-up.
REQ-029 SHALL, on reset asserted mid-run, drop execute in the same cycle and issue nothing after release until a new start.

Structure
REQ-030 SHALL place the HALT_OPCODE constant (16'hFFFF) and the state encoding in a shared package, so core_array-side code and benches agree.
REQ-031 SHALL use one sub-module, prog_mem: a write port plus a combinational read port, no reset on storage.

Verification
REQ-032 SHALL check this load-and-run case:
- stimulus: load 0x1234, 0x5678, 0xFFFF at addresses 0..2, then pulse start;
- response: execute high on two consecutive cycles with opcode 0x1234 then 0x5678, then done one cycle later, busy low.
REQ-033 SHALL check the stall case:
- stimulus: same program, stall=1 for 3 cycles after the first issue;
- response: opcode holds 0x1234, execute low for 3 cycles, then 0x5678 issues; pc does not advance while stalled.
REQ-034 SHALL check the full-depth case:
- stimulus: fill all 16 entries with 0x0000..0x000F (no HALT) and start;
- response: 16 consecutive execute strobes, done on the same edge as the last, pc=0 afterward.
REQ-035 SHALL check writes during RUN:
- stimulus: prog_we to address 1 with 0xAAAA during RUN;
- response: the write is ignored; address 1 still issues its original value.
REQ-036 SHALL check reset mid-run:
- stimulus: assert rst_n=0 during the second issue;
- response: execute=0 and opcode=0 asynchronously; no execute after release until start.
REQ-037 SHALL check HALT at entry 0:
- stimulus: program HALT at entry 0, then start;
- response: zero execute strobes, done pulses one cycle after start.
